// File: rtl/tof_counter.sv
// Time-of-flight counter: measures avmms_clk cycles from a start comparator edge
// to the first unblanked echo edge, with an Avalon-MM register interface.
module tof_counter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        avmms_clk,
  input  logic        avmms_reset_n,
  input  logic        start_in,
  input  logic        stop_in,
  input  logic        avmms_cs,
  input  logic [2:0]  avmms_address,
  input  logic        avmms_write,
  input  logic [31:0] avmms_writedata,
  input  logic        avmms_read,
  output logic [31:0] avmms_readdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd2;
  localparam logic [2:0] ADDR_RESULT  = 3'd3;
  localparam logic [2:0] ADDR_BLANK   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
  logic [SYNC_STAGES-1:0] stop_sync_q, stop_sync_d;
  logic                   start_prev_q, start_prev_d;
  logic                   stop_prev_q, stop_prev_d;
  logic                   enable_q, enable_d;
  logic                   irq_en_q, irq_en_d;
  logic [CNT_W-1:0]       timeout_val_q, timeout_val_d;
  logic [CNT_W-1:0]       blank_q, blank_d;
  logic [CNT_W-1:0]       result_q, result_d;
  logic [CNT_W-1:0]       counter_q, counter_d;
  logic [7:0]             hit_cnt_q, hit_cnt_d;
  logic                   done_q, done_d;
  logic                   timeout_flag_q, timeout_flag_d;
  logic [31:0]            readdata_q, readdata_d;

  logic        start_edge, stop_edge;
  logic        wr_en, rd_en, arm_pulse, busy;
  logic        stop_valid, timeout_hit, sat_hit;
  logic [31:0] rd_word;
  logic        unused_wdata;

  assign unused_wdata = ^avmms_writedata;

  // Both comparator paths share the same depth, so their latency cancels out.
  always_comb begin
    start_sync_d = {start_sync_q[SYNC_STAGES-2:0], start_in};
    stop_sync_d  = {stop_sync_q[SYNC_STAGES-2:0], stop_in};
    start_prev_d = start_sync_q[SYNC_STAGES-1];
    stop_prev_d  = stop_sync_q[SYNC_STAGES-1];
  end

  assign start_edge = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
  assign stop_edge  = stop_sync_q[SYNC_STAGES-1] & ~stop_prev_q;

  assign wr_en     = avmms_cs & avmms_write;
  assign rd_en     = avmms_cs & avmms_read;
  assign arm_pulse = wr_en && (avmms_address == ADDR_CTRL) &&
                     avmms_writedata[1] && avmms_writedata[0];
  assign busy      = (state_q == ARMED) || (state_q == COUNTING);

  // counter_q lags elapsed clocks by one, so timeout fires when it equals TIMEOUT-1.
  assign stop_valid  = stop_edge && (counter_q >= blank_q);
  assign timeout_hit = (timeout_val_q != '0) && (counter_q == timeout_val_q - CNT_W'(1));
  assign sat_hit     = (timeout_val_q == '0) && (counter_q == CNT_MAX);

  always_comb begin
    state_d        = state_q;
    enable_d       = enable_q;
    irq_en_d       = irq_en_q;
    timeout_val_d  = timeout_val_q;
    blank_d        = blank_q;
    result_d       = result_q;
    counter_d      = counter_q;
    hit_cnt_d      = hit_cnt_q;
    done_d         = done_q;
    timeout_flag_d = timeout_flag_q;

    if (wr_en) begin
      case (avmms_address)
        ADDR_CTRL: begin
          enable_d = avmms_writedata[0];
          irq_en_d = avmms_writedata[2];
        end
        ADDR_STATUS: begin
          done_d         = 1'b0;
          timeout_flag_d = 1'b0;
        end
        ADDR_TIMEOUT: timeout_val_d = avmms_writedata[CNT_W-1:0];
        ADDR_BLANK:   blank_d       = avmms_writedata[CNT_W-1:0];
        default: ;
      endcase
    end

    // A completing measurement sets done after any STATUS clear in the same cycle.
    if (arm_pulse) begin
      state_d        = ARMED;
      counter_d      = '0;
      hit_cnt_d      = '0;
      done_d         = 1'b0;
      timeout_flag_d = 1'b0;
    end else if (!enable_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ARMED: begin
          if (start_edge) begin
            state_d   = COUNTING;
            counter_d = '0;
          end
        end
        COUNTING: begin
          counter_d = counter_q + CNT_W'(1);
          if (stop_valid) begin
            if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
            result_d = (counter_q == CNT_MAX) ? CNT_MAX : counter_q + CNT_W'(1);
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (timeout_hit) begin
            result_d       = timeout_val_q;
            done_d         = 1'b1;
            timeout_flag_d = 1'b1;
            state_d        = DONE;
          end else if (sat_hit) begin
            result_d       = CNT_MAX;
            done_d         = 1'b1;
            timeout_flag_d = 1'b1;
            state_d        = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (avmms_address)
      ADDR_CTRL: begin
        rd_word[0] = enable_q;
        rd_word[2] = irq_en_q;
      end
      ADDR_STATUS: begin
        rd_word[0]    = busy;
        rd_word[1]    = done_q;
        rd_word[2]    = timeout_flag_q;
        rd_word[15:8] = hit_cnt_q;
      end
      ADDR_TIMEOUT: rd_word[CNT_W-1:0] = timeout_val_q;
      ADDR_RESULT:  rd_word[CNT_W-1:0] = result_q;
      ADDR_BLANK:   rd_word[CNT_W-1:0] = blank_q;
      default: ;
    endcase
    readdata_d = rd_en ? rd_word : readdata_q;
  end

  always_ff @(posedge avmms_clk or negedge avmms_reset_n) begin
    if (!avmms_reset_n) begin
      state_q        <= IDLE;
      start_sync_q   <= '0;
      stop_sync_q    <= '0;
      start_prev_q   <= 1'b0;
      stop_prev_q    <= 1'b0;
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      timeout_val_q  <= '0;
      blank_q        <= '0;
      result_q       <= '0;
      counter_q      <= '0;
      hit_cnt_q      <= '0;
      done_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      readdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      start_sync_q   <= start_sync_d;
      stop_sync_q    <= stop_sync_d;
      start_prev_q   <= start_prev_d;
      stop_prev_q    <= stop_prev_d;
      enable_q       <= enable_d;
      irq_en_q       <= irq_en_d;
      timeout_val_q  <= timeout_val_d;
      blank_q        <= blank_d;
      result_q       <= result_d;
      counter_q      <= counter_d;
      hit_cnt_q      <= hit_cnt_d;
      done_q         <= done_d;
      timeout_flag_q <= timeout_flag_d;
      readdata_q     <= readdata_d;
    end
  end

  assign avmms_readdata = readdata_q;
  assign irq            = done_q & irq_en_q;

endmodule

// File: tb/tb_tof_counter.sv
// Bench for tof_counter: drives comparator pulses at chosen clock offsets and
// compares result, status and interrupt timing against a scoreboard queue.
module tb_tof_counter;

  localparam int CNT_W       = 24;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_TIMEOUT = 3'd2;
  localparam logic [2:0] A_RESULT  = 3'd3;
  localparam logic [2:0] A_BLANK   = 3'd4;

  typedef struct {
    int result;
    int status;
    int irqCyc;
  } expT;

  logic        clock = 1'b0;
  logic        resetN;
  logic        startIn, stopIn;
  logic        cs, write, read;
  logic [2:0]  address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        irq;

  int          assertCount = 0;
  int          failCount   = 0;
  expT         expQ[$];
  logic [31:0] rd;
  int          irqCyc;

  tof_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .avmms_clk       (clock),
    .avmms_reset_n   (resetN),
    .start_in        (startIn),
    .stop_in         (stopIn),
    .avmms_cs        (cs),
    .avmms_address   (address),
    .avmms_write     (write),
    .avmms_writedata (writeData),
    .avmms_read      (read),
    .avmms_readdata  (readData),
    .irq             (irq)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    @(negedge clock);
    cs = 1'b1; write = 1'b1; address = a; writeData = d;
    @(negedge clock);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] a, output logic [31:0] d);
    @(negedge clock);
    cs = 1'b1; read = 1'b1; address = a;
    @(negedge clock);
    d = readData;
    cs = 1'b0; read = 1'b0;
  endtask

  function automatic bit inPulse(input int cyc, input int at);
    return (at >= 0) && (cyc >= at) && (cyc < at + 2);
  endfunction

  // Cycle indices count negedges from the call; irq is sampled before driving.
  task automatic applyStimulus(input int startAt, input int start2At, input int stop1At,
                               input int stop2At, input int armAt, input int maxCyc,
                               output int irqSeen);
    irqSeen = -1;
    for (int cyc = 0; cyc <= maxCyc; cyc++) begin
      @(negedge clock);
      if (irq && irqSeen < 0) irqSeen = cyc;
      startIn = inPulse(cyc, startAt) || inPulse(cyc, start2At);
      stopIn  = inPulse(cyc, stop1At) || inPulse(cyc, stop2At);
      if (cyc == armAt) begin
        cs = 1'b1; write = 1'b1; address = A_CTRL; writeData = 32'h7;
      end else begin
        cs = 1'b0; write = 1'b0;
      end
    end
    startIn = 1'b0; stopIn = 1'b0; cs = 1'b0; write = 1'b0;
  endtask

  task automatic runCase(input string name, input int blank, input int timeoutV,
                         input int startAt, input int start2At, input int stop1At,
                         input int stop2At, input int armAt, input int expResult,
                         input int expStatus, input int expIrqCyc);
    expT e;
    int seen;
    logic [31:0] v;
    busWrite(A_BLANK, blank);
    busWrite(A_TIMEOUT, timeoutV);
    busWrite(A_CTRL, 32'h7);
    expQ.push_back('{expResult, expStatus, expIrqCyc});
    applyStimulus(startAt, start2At, stop1At, stop2At, armAt, expIrqCyc + 5, seen);
    e = expQ.pop_front();
    checkOutput({name, " irq_cycle"}, seen, e.irqCyc);
    busRead(A_RESULT, v);
    checkOutput({name, " result"}, v, e.result);
    busRead(A_STATUS, v);
    checkOutput({name, " status"}, v, e.status);
    checkOutput({name, " irq_held"}, {31'b0, irq}, 32'd1);
    busWrite(A_STATUS, 32'h0);
    checkOutput({name, " irq_cleared"}, {31'b0, irq}, 32'd0);
    busRead(A_STATUS, v);
    checkOutput({name, " status_cleared"}, v, e.status & 32'hFF00);
  endtask

  initial begin
    resetN = 1'b0; startIn = 1'b0; stopIn = 1'b0;
    cs = 1'b0; write = 1'b0; read = 1'b0; address = 3'd0; writeData = 32'h0;

    repeat (3) @(negedge clock);
    checkOutput("reset readdata", readData, 32'h0);
    checkOutput("reset irq", {31'b0, irq}, 32'd0);
    resetN = 1'b1;
    busRead(A_STATUS, rd);
    checkOutput("reset status", rd, 32'h0);
    busRead(A_CTRL, rd);
    checkOutput("reset ctrl", rd, 32'h0);
    busRead(A_RESULT, rd);
    checkOutput("reset result", rd, 32'h0);

    $display("[TB] basic start/stop spacing");
    runCase("basic", 0, 0, 2, -1, 15, -1, -1, 13, 32'h102, 15 + LAT);

    $display("[TB] blanking window");
    runCase("blank", 20, 0, 2, -1, 12, 27, -1, 25, 32'h102, 27 + LAT);

    $display("[TB] timeout");
    runCase("timeout", 0, 50, 2, -1, -1, -1, -1, 50, 32'h006, 2 + 50 + LAT);

    $display("[TB] simultaneous start and stop");
    runCase("simul", 0, 0, 2, -1, 2, 9, -1, 7, 32'h102, 9 + LAT);

    $display("[TB] re-arm while counting");
    runCase("rearm", 0, 0, 2, 12, 21, -1, 7, 9, 32'h102, 21 + LAT);

    $display("[TB] reset during counting");
    busWrite(A_BLANK, 32'h0);
    busWrite(A_TIMEOUT, 32'h0);
    busWrite(A_CTRL, 32'h7);
    busRead(A_RESULT, rd);
    checkOutput("pre-reset result", rd, 32'd9);
    applyStimulus(2, -1, -1, -1, -1, 9, irqCyc);
    checkOutput("pre-reset no irq", irqCyc, -1);
    busRead(A_STATUS, rd);
    checkOutput("pre-reset busy", rd, 32'h1);
    resetN = 1'b0;
    #1;
    checkOutput("mid reset readdata", readData, 32'h0);
    checkOutput("mid reset irq", {31'b0, irq}, 32'd0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    busRead(A_STATUS, rd);
    checkOutput("post-reset status", rd, 32'h0);
    busRead(A_RESULT, rd);
    checkOutput("post-reset result", rd, 32'h0);
    busRead(A_CTRL, rd);
    checkOutput("post-reset ctrl", rd, 32'h0);
    busRead(A_TIMEOUT, rd);
    checkOutput("post-reset timeout", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
